// File: rtl/synchro_cmd_debouncer.sv
// Two-button command front end for synchro_register.
// Synchronise, debounce, arbitrate and count accepted commands.
module synchro_cmd_debouncer_fsm #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] LOW       = 2'd0;
  localparam logic [1:0] RISE_WAIT = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;
  localparam logic [1:0] FALL_WAIT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOW: begin
        if (s) begin
          state_nxt = RISE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_nxt = LOW;
        end else if (cnt == LAST) begin
          state_nxt = HIGH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = FALL_WAIT;
          cnt_nxt   = '0;
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_nxt = HIGH;
        end else if (cnt == LAST) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Level stays asserted while a release is still being qualified
  assign db = (state == HIGH) || (state == FALL_WAIT);

endmodule

module synchro_cmd_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BTN_Z,
  input  logic             BTN_O,
  output logic             ZEROES,
  output logic             ONES,
  output logic             CONFLICT,
  output logic [CNT_W-1:0] EVT_CNT
);

  logic [1:0] sync_z;
  logic [1:0] sync_o;
  logic       db_z;
  logic       db_o;
  logic       zeroes_nxt;
  logic       ones_nxt;
  logic       conflict_nxt;
  logic       evt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_z <= '0;
      sync_o <= '0;
    end else begin
      sync_z <= {sync_z[0], BTN_Z};
      sync_o <= {sync_o[0], BTN_O};
    end
  end

  synchro_cmd_debouncer_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_z (
    .clk(CLK),
    .rst(RESET),
    .s  (sync_z[1]),
    .db (db_z)
  );

  synchro_cmd_debouncer_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_o (
    .clk(CLK),
    .rst(RESET),
    .s  (sync_o[1]),
    .db (db_o)
  );

  // No priority: simultaneous presses drop both commands
  always_comb begin
    ones_nxt     = db_o & ~db_z;
    zeroes_nxt   = db_z & ~db_o;
    conflict_nxt = db_z & db_o;
    evt          = (ones_nxt & ~ONES) | (zeroes_nxt & ~ZEROES);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ZEROES   <= 1'b0;
      ONES     <= 1'b0;
      CONFLICT <= 1'b0;
      EVT_CNT  <= '0;
    end else begin
      ZEROES   <= zeroes_nxt;
      ONES     <= ones_nxt;
      CONFLICT <= conflict_nxt;
      if (evt) begin
        EVT_CNT <= EVT_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synchro_cmd_debouncer.sv
// Directed bench for synchro_cmd_debouncer.
// Expectations are queued with the stimulus and popped on output.
module tb_synchro_cmd_debouncer;

  logic       CLK;
  logic       RESET;
  logic       BTN_Z;
  logic       BTN_O;
  logic       ZEROES;
  logic       ONES;
  logic       CONFLICT;
  logic [7:0] EVT_CNT;

  typedef struct {
    string      tag;
    logic [10:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ev = 8'd0;

  synchro_cmd_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BTN_Z   (BTN_Z),
    .BTN_O   (BTN_O),
    .ZEROES  (ZEROES),
    .ONES    (ONES),
    .CONFLICT(CONFLICT),
    .EVT_CNT (EVT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input string tag, input logic z, input logic o,
                      input logic c, input logic [7:0] cnt);
    exp_t e;
    e.tag = tag;
    e.val = {z, o, c, cnt};
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [10:0] got;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got empty queue, expected entry");
      return;
    end
    e   = exp_q.pop_front();
    got = {ZEROES, ONES, CONFLICT, EVT_CNT};
    checks++;
    assert (got === e.val) else begin
      errors++;
      $error("FAIL %s: got z=%b o=%b c=%b cnt=%0d, expected z=%b o=%b c=%b cnt=%0d",
             e.tag, got[10], got[9], got[8], got[7:0],
             e.val[10], e.val[9], e.val[8], e.val[7:0]);
    end
  endtask

  task automatic press_o(input int hold);
    BTN_O = 1'b1;
    tick(hold);
    BTN_O = 1'b0;
    tick(hold);
  endtask

  initial begin
    RESET = 1'b1;
    BTN_Z = 1'b0;
    BTN_O = 1'b1;
    // 1 reset holds everything low with a button pressed
    for (int i = 0; i < 5; i++) begin
      push("reset", 1'b0, 1'b0, 1'b0, 8'd0);
      tick(1);
      pop_check();
    end
    RESET = 1'b0;
    BTN_O = 1'b0;
    tick(10);
    push("idle", 1'b0, 1'b0, 1'b0, 8'd0);
    pop_check();

    // 2 clean press
    BTN_O = 1'b1;
    push("press_pre", 1'b0, 1'b0, 1'b0, 8'd0);
    ev++;
    push("press_rise", 1'b0, 1'b1, 1'b0, ev);
    tick(7);
    pop_check();
    tick(1);
    pop_check();
    tick(4);
    BTN_O = 1'b0;
    push("release_pre", 1'b0, 1'b1, 1'b0, ev);
    push("release_fall", 1'b0, 1'b0, 1'b0, ev);
    tick(7);
    pop_check();
    tick(1);
    pop_check();
    tick(4);

    // 3 short glitch is rejected
    BTN_Z = 1'b1;
    tick(3);
    BTN_Z = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push("glitch", 1'b0, 1'b0, 1'b0, ev);
      tick(1);
      pop_check();
    end

    // 4 bounce then steady high
    BTN_O = 1'b1;
    tick(1);
    BTN_O = 1'b0;
    tick(1);
    BTN_O = 1'b1;
    tick(1);
    BTN_O = 1'b0;
    tick(1);
    BTN_O = 1'b1;
    push("bounce_pre", 1'b0, 1'b0, 1'b0, ev);
    ev++;
    push("bounce_rise", 1'b0, 1'b1, 1'b0, ev);
    tick(7);
    pop_check();
    tick(1);
    pop_check();
    tick(4);
    BTN_O = 1'b0;
    push("bounce_fall", 1'b0, 1'b0, 1'b0, ev);
    tick(8);
    pop_check();
    tick(4);

    // 5 conflict
    BTN_Z = 1'b1;
    ev++;
    push("z_rise", 1'b1, 1'b0, 1'b0, ev);
    tick(8);
    pop_check();
    tick(2);
    BTN_O = 1'b1;
    push("conf_pre", 1'b1, 1'b0, 1'b0, ev);
    push("conf_on", 1'b0, 1'b0, 1'b1, ev);
    tick(7);
    pop_check();
    tick(1);
    pop_check();
    tick(3);
    BTN_Z = 1'b0;
    push("conf_hold", 1'b0, 1'b0, 1'b1, ev);
    ev++;
    push("conf_off", 1'b0, 1'b1, 1'b0, ev);
    tick(7);
    pop_check();
    tick(1);
    pop_check();
    BTN_O = 1'b0;
    push("conf_idle", 1'b0, 1'b0, 1'b0, ev);
    tick(10);
    pop_check();

    // 6 reset in the middle of a rise qualification
    BTN_Z = 1'b1;
    tick(4);
    RESET = 1'b1;
    ev = 8'd0;
    for (int i = 0; i < 2; i++) begin
      push("mid_reset", 1'b0, 1'b0, 1'b0, ev);
      tick(1);
      pop_check();
    end
    RESET = 1'b0;
    push("after_rst_pre", 1'b0, 1'b0, 1'b0, ev);
    ev++;
    push("after_rst_rise", 1'b1, 1'b0, 1'b0, ev);
    tick(7);
    pop_check();
    tick(1);
    pop_check();
    BTN_Z = 1'b0;
    tick(10);

    // counter wrap
    while (ev != 8'd255) begin
      press_o(10);
      ev++;
    end
    push("cnt_255", 1'b0, 1'b0, 1'b0, ev);
    pop_check();
    BTN_O = 1'b1;
    ev++;
    push("cnt_wrap", 1'b0, 1'b1, 1'b0, ev);
    tick(8);
    pop_check();
    BTN_O = 1'b0;
    tick(10);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_left: got %0d entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
